// File: rtl/peripheral_arbiter_wb.sv
// -----------------------------------------------------------------------------
// peripheral_arbiter_wb
//
// Round-robin Wishbone arbiter sharing one slave port between NUM_MASTERS
// masters. A grant is taken in IDLE, held for the whole Wishbone cycle
// (classic or burst) while the owner keeps m_cyc_i high, and released through
// IDLE so the shared bus is idle for at least one clock between owners. The
// master that just released has the lowest priority at the next arbitration.
//
// Optional build macro: PERIPHERAL_ARBITER_WB_TIMEOUT_EN
//   Adds a watchdog counting strobed clocks without a slave response. When it
//   expires the owner gets a one-clock m_err_o, and s_cyc_o/s_stb_o are held
//   low until that master drops cyc. Without the macro a hung slave keeps the
//   grant forever.
//
// Ports:
//   wb_clk_i, wb_rst_ni       clock, asynchronous active-low reset
//   m_*_i                     packed master request buses, master k at [k*W+:W]
//   m_dat_o/ack/err/rty       read data (broadcast) and per-master responses
//   s_*_o / s_*_i             single shared slave port
//   grant_o                   one-hot current owner, for debug
// -----------------------------------------------------------------------------
module peripheral_arbiter_wb #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 256
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  output logic [NUM_MASTERS*DW-1:0]   m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int SW = DW / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]          r_gidx,  w_gidx_nxt;
  logic [IW-1:0]          r_last,  w_last_nxt;
  logic [IW-1:0]          w_pick;
  logic                   w_found;
  logic                   w_kill;     // watchdog is suppressing the forwarded cycle
  logic                   w_tmo_err;  // one-clock watchdog error to the owner

  // Round-robin search: first requester after the last owner, wrapping.
  always_comb begin
    int k;
    k       = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      k = int'(r_last) + i;
      if (k >= NUM_MASTERS) k = k - NUM_MASTERS;
      if (!w_found && m_cyc_i[k]) begin
        w_found = 1'b1;
        w_pick  = k[IW-1:0];
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = NUM_MASTERS'(1) << w_pick;
          w_gidx_nxt  = w_pick;
        end
      end
      ST_GRANT: begin
        // Held regardless of cti/bte: only the owner's cyc ends the tenure.
        if (!m_cyc_i[r_gidx]) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = r_gidx;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);  // master 0 wins the first arbitration
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Forwarding mux; r_grant is zero in IDLE so the slave sees an idle bus.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (r_grant[k]) begin
        s_adr_o = m_adr_i[k*AW +: AW];
        s_dat_o = m_dat_i[k*DW +: DW];
        s_sel_o = m_sel_i[k*SW +: SW];
        s_we_o  = m_we_i[k];
        s_cti_o = m_cti_i[k*3 +: 3];
        s_bte_o = m_bte_i[k*2 +: 2];
        s_cyc_o = m_cyc_i[k] & ~w_kill;
        s_stb_o = m_stb_i[k] & ~w_kill;
      end
    end
  end

  assign m_dat_o = {NUM_MASTERS{s_dat_i}};
  assign m_ack_o = r_grant & {NUM_MASTERS{s_ack_i}};
  assign m_err_o = r_grant & {NUM_MASTERS{s_err_i | w_tmo_err}};
  assign m_rty_o = r_grant & {NUM_MASTERS{s_rty_i}};
  assign grant_o = r_grant;

`ifdef PERIPHERAL_ARBITER_WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_tmo_cnt;
  logic          r_tmo_kill;
  logic          w_stb_raw;

  // The expiry decision uses the master's own strobe, not s_stb_o, so the
  // suppression it causes cannot feed back into it.
  assign w_stb_raw = |(r_grant & m_stb_i);
  assign w_tmo_err = (r_state == ST_GRANT) && !r_tmo_kill && w_stb_raw &&
                     (r_tmo_cnt == CW'(TIMEOUT - 1));
  assign w_kill    = r_tmo_kill | w_tmo_err;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_tmo_cnt  <= '0;
      r_tmo_kill <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || s_ack_i || s_err_i || s_rty_i || !s_stb_o)
        r_tmo_cnt <= '0;
      else
        r_tmo_cnt <= r_tmo_cnt + 1'b1;

      if (r_state == ST_IDLE)
        r_tmo_kill <= 1'b0;
      else if (w_tmo_err)
        r_tmo_kill <= 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_tmo_err        = 1'b0;
  assign w_kill           = 1'b0;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// -----------------------------------------------------------------------------
// tb_peripheral_arbiter_wb
//
// Bench for peripheral_arbiter_wb with three masters: a vector table for
// arbitration order and response routing, hand sequences for burst hold,
// asynchronous reset and (with PERIPHERAL_ARBITER_WB_TIMEOUT_EN) the watchdog,
// then random traffic against an owner/last-owner reference model.
// -----------------------------------------------------------------------------
module tb_peripheral_arbiter_wb;

  localparam int NM  = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*DW/8-1:0] m_sel_i;
  logic [NM-1:0]     m_we_i;
  logic [NM*3-1:0]   m_cti_i;
  logic [NM*2-1:0]   m_bte_i;
  logic [NM-1:0]     m_cyc_i;
  logic [NM-1:0]     m_stb_i;
  logic [NM*DW-1:0]  m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic              s_we_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic              s_cyc_o, s_stb_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i, s_rty_i;
  logic [NM-1:0]     grant_o;

  always #5 clk = ~clk;

  peripheral_arbiter_wb #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [NM-1:0] cyc;
    logic          ack;
    logic          err;
    logic          rty;
    logic [NM-1:0] eg;   // expected grant_o
    logic          ec;   // expected s_cyc_o
    logic [NM-1:0] ea;   // expected m_ack_o
    logic [NM-1:0] ee;   // expected m_err_o
    logic [NM-1:0] er;   // expected m_rty_o
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [NM-1:0] cyc, input logic ack, input logic err,
                     input logic rty, input logic [NM-1:0] eg, input logic ec,
                     input logic [NM-1:0] ea, input logic [NM-1:0] ee,
                     input logic [NM-1:0] er);
    vec_t v;
    v.cyc = cyc; v.ack = ack; v.err = err; v.rty = rty;
    v.eg = eg; v.ec = ec; v.ea = ea; v.ee = ee; v.er = er;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
    m_cti_i = '0; m_bte_i = '0; m_cyc_i = '0; m_stb_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_grant", grant_o, '0);
    check("reset_scyc", {s_cyc_o, s_stb_o}, 2'b00);
    check("reset_resp", {m_ack_o, m_err_o, m_rty_o}, '0);
    rst_n = 1'b1;
    next_cycle();
  endtask

  logic [AW-1:0] adr_tab [NM];
  logic [DW-1:0] dat_tab [NM];

  // Reference model state for the random phase.
  int owner;
  int last;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    adr_tab[0] = 32'h0000_0010; adr_tab[1] = 32'h0000_0110; adr_tab[2] = 32'h0000_0210;
    dat_tab[0] = 32'hDEAD_BEEF; dat_tab[1] = 32'h1111_1111; dat_tab[2] = 32'h2222_2222;

    // ---------------- vector table ----------------
    //   cyc    ack  err  rty  | grant  scyc  ack    err    rty
    add(3'b000, 0,   0,   0,     3'b000, 0, 3'b000, 3'b000, 3'b000);
    add(3'b011, 0,   0,   0,     3'b000, 0, 3'b000, 3'b000, 3'b000);
    add(3'b011, 1,   0,   0,     3'b001, 1, 3'b001, 3'b000, 3'b000);
    add(3'b010, 0,   0,   0,     3'b001, 0, 3'b000, 3'b000, 3'b000);
    add(3'b011, 1,   0,   0,     3'b000, 0, 3'b000, 3'b000, 3'b000);
    add(3'b011, 1,   0,   0,     3'b010, 1, 3'b010, 3'b000, 3'b000);
    add(3'b001, 0,   0,   0,     3'b010, 0, 3'b000, 3'b000, 3'b000);
    add(3'b011, 0,   0,   0,     3'b000, 0, 3'b000, 3'b000, 3'b000);
    add(3'b011, 0,   1,   0,     3'b001, 1, 3'b000, 3'b001, 3'b000);
    add(3'b000, 0,   0,   0,     3'b001, 0, 3'b000, 3'b000, 3'b000);
    add(3'b000, 1,   1,   0,     3'b000, 0, 3'b000, 3'b000, 3'b000);
    add(3'b100, 0,   0,   0,     3'b000, 0, 3'b000, 3'b000, 3'b000);
    add(3'b100, 0,   0,   1,     3'b100, 1, 3'b000, 3'b000, 3'b100);
    add(3'b000, 0,   0,   0,     3'b100, 0, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0,   0,   0,     3'b000, 0, 3'b000, 3'b000, 3'b000);
    add(3'b001, 0,   0,   0,     3'b000, 0, 3'b000, 3'b000, 3'b000);
    add(3'b011, 1,   0,   0,     3'b001, 1, 3'b001, 3'b000, 3'b000);
    add(3'b001, 0,   0,   0,     3'b001, 1, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0,   0,   0,     3'b001, 0, 3'b000, 3'b000, 3'b000);
    add(3'b100, 0,   0,   0,     3'b000, 0, 3'b000, 3'b000, 3'b000);
    add(3'b100, 0,   0,   0,     3'b100, 1, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0,   0,   0,     3'b100, 0, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0,   0,   0,     3'b000, 0, 3'b000, 3'b000, 3'b000);

    do_reset();
    for (int k = 0; k < NM; k++) begin
      m_adr_i[k*AW +: AW] = adr_tab[k];
      m_dat_i[k*DW +: DW] = dat_tab[k];
      m_sel_i[k*4 +: 4]   = 4'hF;
    end
    m_we_i = 3'b001;

    for (int i = 0; i < vq.size(); i++) begin
      logic [DW-1:0] rd;
      int ek;
      rd = 32'hCAFE_0000 + DW'(i);
      m_cyc_i = vq[i].cyc; m_stb_i = vq[i].cyc;
      s_ack_i = vq[i].ack; s_err_i = vq[i].err; s_rty_i = vq[i].rty;
      s_dat_i = rd;
      @(negedge clk);
      check($sformatf("tbl%0d_grant", i), grant_o, vq[i].eg);
      check($sformatf("tbl%0d_scyc", i), s_cyc_o, vq[i].ec);
      check($sformatf("tbl%0d_ack", i), m_ack_o, vq[i].ea);
      check($sformatf("tbl%0d_err", i), m_err_o, vq[i].ee);
      check($sformatf("tbl%0d_rty", i), m_rty_o, vq[i].er);
      check($sformatf("tbl%0d_rdat", i), m_dat_o, {NM{rd}});
      if (vq[i].ec) begin
        ek = 0;
        for (int k = 0; k < NM; k++) if (vq[i].eg[k]) ek = k;
        check($sformatf("tbl%0d_sadr", i), s_adr_o, adr_tab[ek]);
        check($sformatf("tbl%0d_sdat", i), s_dat_o, dat_tab[ek]);
        check($sformatf("tbl%0d_swe", i), s_we_o, (ek == 0));
      end
      next_cycle();
    end

    // ---------------- burst on master 1 while master 0 waits ----------------
    idle_inputs();
    m_cyc_i = 3'b010; m_stb_i = 3'b010;
    m_cti_i[3 +: 3] = 3'b010;
    m_adr_i[AW +: AW] = 32'h200;
    @(negedge clk);
    check("burst_req_idle", grant_o, 3'b000);
    next_cycle();
    begin
      int beats;
      beats = 0;
      for (int b = 0; b < 4; b++) begin
        m_cyc_i = 3'b011; m_stb_i = 3'b011;
        m_adr_i[AW +: AW] = 32'h200 + 32'(4 * b);
        m_cti_i[3 +: 3] = (b == 3) ? 3'b111 : 3'b010;
        s_ack_i = 1'b1;
        @(negedge clk);
        check($sformatf("burst%0d_grant", b), grant_o, 3'b010);
        check($sformatf("burst%0d_ack", b), m_ack_o, 3'b010);
        check($sformatf("burst%0d_adr", b), s_adr_o, 32'h200 + 32'(4 * b));
        check($sformatf("burst%0d_cti", b), s_cti_o, (b == 3) ? 3'b111 : 3'b010);
        if (m_ack_o[1]) beats++;
        next_cycle();
      end
      check("burst_beats", beats, 4);
    end
    m_cyc_i = 3'b001; m_stb_i = 3'b001; s_ack_i = 1'b0;
    @(negedge clk);
    check("burst_end_grant", grant_o, 3'b010);
    check("burst_end_scyc", s_cyc_o, 1'b0);
    next_cycle();
    @(negedge clk);
    check("burst_gap_grant", grant_o, 3'b000);
    check("burst_gap_scyc", s_cyc_o, 1'b0);
    next_cycle();
    @(negedge clk);
    check("burst_m0_grant", grant_o, 3'b001);
    check("burst_m0_scyc", s_cyc_o, 1'b1);
    next_cycle();
    m_cyc_i = '0; m_stb_i = '0;
    repeat (2) next_cycle();

    // ---------------- async reset mid-burst ----------------
    m_cyc_i = 3'b010; m_stb_i = 3'b010; m_cti_i[3 +: 3] = 3'b010;
    next_cycle();
    m_cyc_i = 3'b011; m_stb_i = 3'b011; s_ack_i = 1'b1;
    @(negedge clk);
    check("rstmid_pre_grant", grant_o, 3'b010);
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_scyc", s_cyc_o, 1'b0);
    check("rstmid_grant", grant_o, 3'b000);
    s_ack_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("rstmid_first_grant", grant_o, 3'b001);
    check("rstmid_first_scyc", s_cyc_o, 1'b1);
    next_cycle();
    m_cyc_i = '0; m_stb_i = '0;
    repeat (2) next_cycle();

`ifdef PERIPHERAL_ARBITER_WB_TIMEOUT_EN
    // ---------------- watchdog: slave never answers ----------------
    m_cyc_i = 3'b001; m_stb_i = 3'b001;
    m_adr_i[0 +: AW] = 32'h0001_0000;
    @(negedge clk);
    check("tmo_idle", grant_o, 3'b000);
    next_cycle();
    m_cyc_i = 3'b011; m_stb_i = 3'b011;
    for (int c = 1; c <= TMO + 1; c++) begin
      @(negedge clk);
      if (c < TMO) begin
        check($sformatf("tmo_c%0d_stb", c), s_stb_o, 1'b1);
        check($sformatf("tmo_c%0d_err", c), m_err_o, 3'b000);
      end else if (c == TMO) begin
        check("tmo_hit_err", m_err_o, 3'b001);
        check("tmo_hit_scyc", {s_cyc_o, s_stb_o}, 2'b00);
      end else begin
        check("tmo_after_err", m_err_o, 3'b000);
        check("tmo_after_scyc", s_cyc_o, 1'b0);
        check("tmo_after_grant", grant_o, 3'b001);
      end
      next_cycle();
    end
    m_cyc_i = 3'b010; m_stb_i = 3'b010;
    @(negedge clk);
    check("tmo_drop_grant", grant_o, 3'b001);
    next_cycle();
    @(negedge clk);
    check("tmo_gap_grant", grant_o, 3'b000);
    next_cycle();
    @(negedge clk);
    check("tmo_next_grant", grant_o, 3'b010);
    check("tmo_next_scyc", s_cyc_o, 1'b1);
    next_cycle();
    m_cyc_i = '0; m_stb_i = '0;
    repeat (2) next_cycle();
`endif

    // ---------------- random traffic vs reference model ----------------
    do_reset();
    owner = -1;
    last  = NM - 1;
    for (int n = 0; n < 300; n++) begin
      logic [NM-1:0] eg, ea, ee, er;
      logic ec, es;
      for (int k = 0; k < NM; k++) begin
        if (m_cyc_i[k]) m_cyc_i[k] = ($urandom_range(0, 5) != 0);
        else            m_cyc_i[k] = ($urandom_range(0, 3) == 0);
        m_stb_i[k] = m_cyc_i[k] & ($urandom_range(0, 3) != 0);
        m_adr_i[k*AW +: AW] = $urandom();
        m_dat_i[k*DW +: DW] = $urandom();
        m_sel_i[k*4 +: 4]   = 4'($urandom_range(0, 15));
        m_we_i[k]           = 1'($urandom_range(0, 1));
      end
      s_dat_i = $urandom();
      s_ack_i = (n % 4 == 0) || ($urandom_range(0, 1) == 1);
      s_err_i = ($urandom_range(0, 7) == 0);
      s_rty_i = ($urandom_range(0, 7) == 0);

      eg = '0; ea = '0; ee = '0; er = '0; ec = 1'b0; es = 1'b0;
      if (owner >= 0) begin
        eg[owner] = 1'b1;
        ea[owner] = s_ack_i;
        ee[owner] = s_err_i;
        er[owner] = s_rty_i;
        ec = m_cyc_i[owner];
        es = m_stb_i[owner];
      end
      @(negedge clk);
      check($sformatf("rnd%0d_grant", n), grant_o, eg);
      check($sformatf("rnd%0d_cycstb", n), {s_cyc_o, s_stb_o}, {ec, es});
      check($sformatf("rnd%0d_resp", n), {m_ack_o, m_err_o, m_rty_o}, {ea, ee, er});
      check($sformatf("rnd%0d_rdat", n), m_dat_o, {NM{s_dat_i}});
      if (owner >= 0)
        check($sformatf("rnd%0d_fwd", n), {s_adr_o, s_dat_o, s_sel_o, s_we_o},
              {m_adr_i[owner*AW +: AW], m_dat_i[owner*DW +: DW],
               m_sel_i[owner*4 +: 4], m_we_i[owner]});

      // Model: owner keeps the bus while its cyc is high; release goes idle
      // for a clock; an idle bus picks the next requester after the last owner.
      if (owner >= 0) begin
        if (!m_cyc_i[owner]) begin
          last  = owner;
          owner = -1;
        end
      end else begin
        for (int j = 1; j <= NM; j++) begin
          int c;
          c = (last + j) % NM;
          if (owner < 0 && m_cyc_i[c]) owner = c;
        end
      end
      next_cycle();
    end

    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/peripheral_arbiter_wb.md
Name: peripheral_arbiter_wb

Overview:
Round-robin Wishbone arbiter that shares one slave port (e.g. the memory BFM or a UART register slave) between NUM_MASTERS masters. A grant is held for the whole Wishbone cycle, including classic and incrementing/wrapping bursts. The block sits between the CPU/DMA/debug master ports and the single shared slave in the MPSoC-UART peripheral bench and subsystem.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
AW, 32, address width
DW, 32, data width (multiple of 8)
TIMEOUT, 256, watchdog limit in clocks (used only with the optional feature)

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  reset, asynchronous, active-low
m_adr_i  in  NUM_MASTERS*AW  master addresses, master k at [k*AW+:AW]
m_dat_i  in  NUM_MASTERS*DW  master write data
m_sel_i  in  NUM_MASTERS*DW/8  byte selects
m_we_i  in  NUM_MASTERS  write enables
m_cti_i  in  NUM_MASTERS*3  cycle type identifiers
m_bte_i  in  NUM_MASTERS*2  burst type extensions
m_cyc_i  in  NUM_MASTERS  cycle requests
m_stb_i  in  NUM_MASTERS  strobes
m_dat_o  out  NUM_MASTERS*DW  read data, broadcast from the slave
m_ack_o  out  NUM_MASTERS  acknowledges
m_err_o  out  NUM_MASTERS  errors
m_rty_o  out  NUM_MASTERS  retries
s_adr_o  out  AW  to slave
s_dat_o  out  DW  to slave
s_sel_o  out  DW/8  to slave
s_we_o  out  1  to slave
s_cti_o  out  3  to slave
s_bte_o  out  2  to slave
s_cyc_o  out  1  to slave
s_stb_o  out  1  to slave
s_dat_i  in  DW  from slave
s_ack_i  in  1  from slave
s_err_i  in  1  from slave
s_rty_i  in  1  from slave
grant_o  out  NUM_MASTERS  one-hot current grant, for debug

Behaviour:
- Reset (wb_rst_ni low, asynchronous): state=IDLE, grant_o=0, last pointer=NUM_MASTERS-1 so master 0 wins first; s_cyc_o=s_stb_o=0; all m_ack_o/m_err_o/m_rty_o=0. Deasserting cyc mid-transfer on reset is legal.
- FSM states: IDLE, GRANT.
- IDLE: if any m_cyc_i is set, select the first requester searching from last+1 upward, modulo NUM_MASTERS. Register the one-hot grant and go to GRANT. s_cyc_o is 0 in IDLE.
- Grant latency: exactly 1 clock from m_cyc_i rising to s_cyc_o rising.
- GRANT, forwarding path: s_* outputs are a combinational mux of the granted master's adr/dat/sel/we/cti/bte/cyc/stb. s_ack_i/s_err_i/s_rty_i are routed only to the granted master. Non-granted masters see 0 on ack/err/rty. s_dat_i is broadcast to every m_dat_o.
- Burst handling: the grant is held while the granted m_cyc_i stays high, independent of cti/bte. Burst address sequencing is the master's and slave's responsibility.
- Release: when the granted m_cyc_i is low in GRANT, go to IDLE, set last=granted index and grant_o=0. The bus is always idle for at least one clock between owners.
- Simultaneous requests: only round-robin order decides. A master that just released has lowest priority next arbitration.
- Requests arriving during GRANT wait; m_cyc_i of waiters is not forwarded.
- A master that drops cyc before being granted is simply skipped.
- NUM_MASTERS=1 degenerates to a registered passthrough with a 1-cycle grant latency.

Optional Feature:
PERIPHERAL_ARBITER_WB_TIMEOUT_EN
- Defined: a counter clears on IDLE, on any s_ack_i/s_err_i/s_rty_i, or when s_stb_o=0, and increments otherwise. When it reaches TIMEOUT, the arbiter:
  - asserts m_err_o of the granted master for one clock,
  - forces s_cyc_o/s_stb_o low from that clock onward,
  - stays in GRANT until that master drops cyc, then releases normally.
- Not defined: no counter is present; a hung slave holds the grant indefinitely.

Test Plan:
- Reset, then master 0 writes 0xDEADBEEF to 0x10 -> s_cyc_o high 1 clock after m_cyc_i[0], grant_o=01, ack seen only on m_ack_o[0].
- Masters 0 and 1 request in the same clock, three times in a row -> grants go 0,1,0; at least one idle clock (s_cyc_o=0) between owners.
- Master 1 runs a 4-beat incrementing burst (cti=010, last beat 111) while master 0 requests -> master 0 stays ungranted until master 1 drops cyc; all 4 beats complete on master 1.
- Slave answers s_err_i for an out-of-range address 0x0001_0000 -> m_err_o pulses only on the granted master; the others stay 0.
- wb_rst_ni pulled low mid-burst -> s_cyc_o and grant_o are 0 immediately (asynchronously); after reset release, master 0 wins first.
- With PERIPHERAL_ARBITER_WB_TIMEOUT_EN and TIMEOUT=16, the slave never acks -> m_err_o pulses on clock 16 of the strobe, s_cyc_o drops, and the next master is granted after the requester drops cyc.
